// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: default widths, instruction
// field positions and opcode encodings. Used by the datapath and controller.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  // Instruction word layout: ir[7:5] opcode, ir[4:0] operand address.
  localparam int OPC_MSB  = 7;
  localparam int OPC_LSB  = 5;
  localparam int OPND_MSB = 4;
  localparam int OPND_LSB = 0;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  // Extract the opcode field from an instruction word.
  function automatic opcode_e get_opcode(input logic [DATA_W_DEF-1:0] instr);
    return opcode_e'(instr[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/cpu_mem.sv
// Program/data memory: combinational read, synchronous single-port write.
// Write source selection (boot port vs. store) is done by the caller.
module cpu_mem
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Synchronous write port.
  // NOTE: storage array has no reset; contents must survive a CPU reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read-before-write: a same-cycle read sees the value prior to the edge.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: PC, IR, AC, ALU (add/pass) and memory.
// Optional build macro CPU_DATAPATH_FLAGS_EN adds carry/zero flag registers;
// without it the carry and zero outputs are tied low.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic              ld_ac,
  input  logic              ld_ir,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              pass,
  input  logic              add,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic              carry,
  output logic              zero,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] ac_q, ac_d;

  logic [ADDR_W-1:0] operand_addr;
  logic [ADDR_W-1:0] mem_raddr, mem_waddr;
  logic [DATA_W-1:0] mem_rdata, mem_wdata, data_opnd, alu_res;
  logic              mem_we, alu_cout;

  assign operand_addr = ir_q[ADDR_W-1:0];

  // Address/write muxing and ALU; the boot port wins over a store.
  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    mem_raddr = ld_ir ? pc_q : operand_addr;
    mem_waddr = prog_we ? prog_addr : operand_addr;
    mem_wdata = prog_we ? prog_data : ac_q;
    // Writes coinciding with an active reset are discarded.
    mem_we    = (prog_we | wr_mem) & reset;
    data_opnd = rd_mem ? mem_rdata : '0;
    {alu_cout, alu_res} = {1'b0, ac_q} + {1'b0, data_opnd};
    if (!add) begin
      // pass, or no operation selected, forwards the operand unchanged
      alu_res  = data_opnd;
      alu_cout = 1'b0;
    end
  end

  cpu_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // Next-state for PC/IR/AC; each register has its own enable.
  always_comb begin
    ir_d = ld_ir ? data_opnd : ir_q;
    ac_d = ld_ac ? alu_res : ac_q;
    pc_d = pc_q;
    if (ld_pc)       pc_d = operand_addr;
    else if (inc_pc) pc_d = pc_q + 1'b1;   // wraps naturally at 2**ADDR_W
  end

  // Architectural registers with asynchronous active-low clear.
  // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      ir_q <= '0;
      ac_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      ac_q <= ac_d;
    end
  end

  assign pc = pc_q;
  assign ir = ir_q;
  assign ac = ac_q;

`ifdef CPU_DATAPATH_FLAGS_EN
  logic carry_q, carry_d;
  logic zero_q, zero_d;

  // Flags follow every accumulator load and hold otherwise.
  always_comb begin
    carry_d = ld_ac ? alu_cout : carry_q;
    zero_d  = ld_ac ? (alu_res == '0) : zero_q;
  end

  // Flag registers share the datapath reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;
`else
  logic unused_cout;
  assign unused_cout = alu_cout;
  assign carry = 1'b0;
  assign zero  = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: a table of per-cycle vectors with
// hand-computed expected register values, plus a hand-written reset sequence.
// Expected values go into a scoreboard queue when a vector is driven and are
// popped and compared after the clock edge that produces them.
module tb_cpu_datapath;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  // Strobe bit positions within a vector's stb field.
  localparam logic [7:0] RD  = 8'h01;
  localparam logic [7:0] WR  = 8'h02;
  localparam logic [7:0] LAC = 8'h04;
  localparam logic [7:0] LIR = 8'h08;
  localparam logic [7:0] LPC = 8'h10;
  localparam logic [7:0] INC = 8'h20;
  localparam logic [7:0] PAS = 8'h40;
  localparam logic [7:0] ADD = 8'h80;

  typedef struct {
    logic        pw;
    logic [4:0]  pa;
    logic [7:0]  pd;
    logic [7:0]  stb;
    logic [4:0]  e_pc;
    logic [7:0]  e_ir;
    logic [7:0]  e_ac;
    logic        e_c;
    logic        e_z;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_mem, wr_mem, ld_ac, ld_ir, ld_pc, inc_pc, pass, add;
  logic [DATA_W-1:0] ir, ac;
  logic [ADDR_W-1:0] pc;
  logic              carry, zero;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t vecs[20];

  always #5 clk = ~clk;

  cpu_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_mem    (rd_mem),
    .wr_mem    (wr_mem),
    .ld_ac     (ld_ac),
    .ld_ir     (ld_ir),
    .ld_pc     (ld_pc),
    .inc_pc    (inc_pc),
    .pass      (pass),
    .add       (add),
    .ir        (ir),
    .pc        (pc),
    .ac        (ac),
    .carry     (carry),
    .zero      (zero),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flags only exist in the flags build; otherwise they must read 0.
  function automatic logic flag(input logic b);
`ifdef CPU_DATAPATH_FLAGS_EN
    return b;
`else
    return 1'b0 & b;
`endif
  endfunction

  function automatic vec_t mk(input logic pw, input logic [4:0] pa, input logic [7:0] pd,
                              input logic [7:0] stb, input logic [4:0] e_pc,
                              input logic [7:0] e_ir, input logic [7:0] e_ac,
                              input logic e_c, input logic e_z);
    vec_t v;
    v.pw = pw; v.pa = pa; v.pd = pd; v.stb = stb;
    v.e_pc = e_pc; v.e_ir = e_ir; v.e_ac = e_ac;
    v.e_c = flag(e_c); v.e_z = flag(e_z);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    prog_we   = v.pw;
    prog_addr = v.pa;
    prog_data = v.pd;
    rd_mem    = v.stb[0];
    wr_mem    = v.stb[1];
    ld_ac     = v.stb[2];
    ld_ir     = v.stb[3];
    ld_pc     = v.stb[4];
    inc_pc    = v.stb[5];
    pass      = v.stb[6];
    add       = v.stb[7];
  endtask

  task automatic check_state(input string tag, input logic [4:0] e_pc, input logic [7:0] e_ir,
                             input logic [7:0] e_ac, input logic e_c, input logic e_z);
    check({tag, ".pc"},    32'(pc),    32'(e_pc));
    check({tag, ".ir"},    32'(ir),    32'(e_ir));
    check({tag, ".ac"},    32'(ac),    32'(e_ac));
    check({tag, ".carry"}, 32'(carry), 32'(e_c));
    check({tag, ".zero"},  32'(zero),  32'(e_z));
  endtask

  // Drive one vector at the falling edge, then compare after the rising edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_state(tag, e.e_pc, e.e_ir, e.e_ac, e.e_c, e.e_z);
    end
  endtask

  initial begin
    // Fetch, load/add, store collision, zero flag, PC wrap/priority, multi-strobe.
    vecs[0]  = mk(1, 5'h00, 8'h43, 8'h00,          5'd0,  8'h00, 8'h00, 0, 0);
    vecs[1]  = mk(1, 5'h03, 8'h80, LIR|RD|INC,     5'd1,  8'h43, 8'h00, 0, 0);
    vecs[2]  = mk(1, 5'h01, 8'h03, 8'h00,          5'd1,  8'h43, 8'h00, 0, 0);
    vecs[3]  = mk(1, 5'h04, 8'h90, LIR|RD|INC,     5'd2,  8'h03, 8'h00, 0, 0);
    vecs[4]  = mk(1, 5'h02, 8'h04, RD|LAC|PAS,     5'd2,  8'h03, 8'h80, 0, 0);
    vecs[5]  = mk(0, 5'h00, 8'h00, LIR|RD|INC,     5'd3,  8'h04, 8'h80, 0, 0);
    vecs[6]  = mk(1, 5'h03, 8'h05, RD|LAC|ADD,     5'd3,  8'h04, 8'h10, 1, 0);
    vecs[7]  = mk(0, 5'h00, 8'h00, LIR|RD,         5'd3,  8'h05, 8'h10, 1, 0);
    vecs[8]  = mk(1, 5'h05, 8'hEE, WR,             5'd3,  8'h05, 8'h10, 1, 0);
    vecs[9]  = mk(0, 5'h00, 8'h00, RD|WR|LAC|PAS,  5'd3,  8'h05, 8'hEE, 0, 0);
    vecs[10] = mk(0, 5'h00, 8'h00, RD|LAC|PAS,     5'd3,  8'h05, 8'h10, 0, 0);
    vecs[11] = mk(1, 5'h05, 8'h00, LAC|PAS,        5'd3,  8'h05, 8'h00, 0, 1);
    vecs[12] = mk(1, 5'h03, 8'h1F, RD|LAC|ADD,     5'd3,  8'h05, 8'h00, 0, 1);
    vecs[13] = mk(0, 5'h00, 8'h00, LIR|RD,         5'd3,  8'h1F, 8'h00, 0, 1);
    vecs[14] = mk(0, 5'h00, 8'h00, LPC,            5'd31, 8'h1F, 8'h00, 0, 1);
    vecs[15] = mk(1, 5'h00, 8'h0A, INC,            5'd0,  8'h1F, 8'h00, 0, 1);
    vecs[16] = mk(0, 5'h00, 8'h00, LIR|RD,         5'd0,  8'h0A, 8'h00, 0, 1);
    vecs[17] = mk(1, 5'h0A, 8'h3C, LPC|INC,        5'd10, 8'h0A, 8'h00, 0, 1);
    vecs[18] = mk(1, 5'h1C, 8'h05, LIR|RD|INC|LAC|PAS, 5'd11, 8'h3C, 8'h3C, 0, 0);
    vecs[19] = mk(0, 5'h00, 8'h00, RD|LAC|ADD|PAS, 5'd11, 8'h3C, 8'h41, 0, 0);

    reset = 1'b0;
    drive(mk(0, 5'h00, 8'h00, 8'h00, 5'd0, 8'h00, 8'h00, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_state("reset_init", 5'd0, 8'h00, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-run reset: preload mem[3]=0x22, bring ac to 0x5A, then reset.
    apply(mk(1, 5'h1C, 8'h5A, 8'h00,      5'd11, 8'h3C, 8'h41, 0, 0), "pre_rst0");
    apply(mk(1, 5'h03, 8'h22, RD|LAC|PAS, 5'd11, 8'h3C, 8'h5A, 0, 0), "pre_rst1");

    @(negedge clk);
    drive(mk(1, 5'h03, 8'h99, LIR|RD|INC|LAC|ADD, 5'd0, 8'h00, 8'h00, 0, 0));
    #2;
    reset = 1'b0;
    #1;
    check_state("rst_async", 5'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_state("rst_held_edge", 5'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    drive(mk(0, 5'h00, 8'h00, 8'h00, 5'd0, 8'h00, 8'h00, 0, 0));
    reset = 1'b1;

    // Memory must still hold 0x22 at address 3 (write during reset dropped).
    apply(mk(1, 5'h00, 8'h03, 8'h00,      5'd0, 8'h00, 8'h00, 0, 0), "post_rst0");
    apply(mk(0, 5'h00, 8'h00, LIR|RD,     5'd0, 8'h03, 8'h00, 0, 0), "post_rst1");
    apply(mk(0, 5'h00, 8'h00, RD|LAC|PAS, 5'd0, 8'h03, 8'h22, 0, 0), "post_rst2");

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
